// File: rtl/ddr_rd_checker.sv
// ddr_rd_checker: issues line reads to ddr2_mgr, compares every returned beat
// against a generated pattern and reports error count, first failure and faults.
module ddr_rd_checker #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 25,
    parameter int unsigned LINE_SHIFT = 12,
    parameter int unsigned LEN_W      = 10,
    parameter int unsigned ERR_W      = 16,
    parameter int unsigned TIMEOUT    = 1023
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [1:0]                   mode,
    input  logic [DATA_W-1:0]            preload,
    input  logic [LEN_W-1:0]             xfr_len,
    input  logic [ADDR_W-LINE_SHIFT-1:0] line_count,
    output logic                         rd_mem_req,
    output logic [ADDR_W-1:0]            rd_mem_addr,
    output logic [LEN_W-1:0]             rd_xfr_len,
    input  logic                         rd_mem_grant,
    input  logic [DATA_W-1:0]            rd_data,
    input  logic                         rd_data_valid,
    output logic                         busy,
    output logic                         done,
    output logic [ERR_W-1:0]             err_cnt,
    output logic [ADDR_W-1:0]            first_err_addr,
    output logic [DATA_W-1:0]            first_err_data,
    output logic [2:0]                   fault
);

    localparam int unsigned LINE_W = ADDR_W - LINE_SHIFT;
    localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);
    localparam int unsigned ROT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_DATA,
        XFR,
        NEXT,
        FIN
    } state_t;

    state_t              state;
    logic [1:0]          mode_q;
    logic [DATA_W-1:0]   preload_q;
    logic [LINE_W-1:0]   lines_q;
    logic [LINE_W-1:0]   line_idx;
    logic [LEN_W-1:0]    beat_idx;
    logic [TO_W-1:0]     to_cnt;

    // registered compare stage
    logic                cmp_valid;
    logic [DATA_W-1:0]   cmp_data;
    logic [DATA_W-1:0]   cmp_exp;
    logic [LINE_W-1:0]   cmp_line;
    logic [LEN_W-1:0]    cmp_beat;

    logic [ROT_W-1:0]    rot_amt;
    logic [2*DATA_W-1:0] rot_dbl;
    logic [DATA_W-1:0]   exp_word;
    logic                take_beat;
    logic                stray;
    logic                last_beat;

    // Expected pattern word for the current beat/line and beat classification
    always_comb begin
        rot_amt   = ROT_W'(32'(beat_idx) % DATA_W);
        rot_dbl   = {preload_q, preload_q} << rot_amt;
        exp_word  = preload_q;
        case (mode_q)
            2'd0:    exp_word = preload_q;
            2'd1:    exp_word = preload_q + DATA_W'(beat_idx);
            2'd2:    exp_word = preload_q ^ DATA_W'(line_idx);
            default: exp_word = rot_dbl[2*DATA_W-1 -: DATA_W];
        endcase
        take_beat = rd_data_valid && ((state == WAIT_DATA) || (state == XFR));
        stray     = rd_data_valid && !((state == WAIT_DATA) || (state == XFR));
        last_beat = (beat_idx == rd_xfr_len - LEN_W'(1));
    end

    // Run sequencing, beat capture, registered compare and status tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            mode_q         <= '0;
            preload_q      <= '0;
            lines_q        <= '0;
            line_idx       <= '0;
            beat_idx       <= '0;
            to_cnt         <= '0;
            cmp_valid      <= 1'b0;
            cmp_data       <= '0;
            cmp_exp        <= '0;
            cmp_line       <= '0;
            cmp_beat       <= '0;
            rd_mem_req     <= 1'b0;
            rd_mem_addr    <= '0;
            rd_xfr_len     <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
            fault          <= '0;
        end else begin
            done      <= 1'b0;
            cmp_valid <= 1'b0;

            if (take_beat) begin
                cmp_valid <= 1'b1;
                cmp_data  <= rd_data;
                cmp_exp   <= exp_word;
                cmp_line  <= line_idx;
                cmp_beat  <= beat_idx;
                beat_idx  <= beat_idx + LEN_W'(1);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q         <= mode;
                        preload_q      <= preload;
                        rd_xfr_len     <= (xfr_len == '0) ? LEN_W'(1) : xfr_len;
                        lines_q        <= (line_count == '0) ? LINE_W'(1) : line_count;
                        line_idx       <= '0;
                        beat_idx       <= '0;
                        err_cnt        <= '0;
                        first_err_addr <= '0;
                        first_err_data <= '0;
                        fault          <= '0;
                        rd_mem_addr    <= '0;
                        rd_mem_req     <= 1'b1;
                        busy           <= 1'b1;
                        state          <= REQ;
                    end
                end
                REQ: begin
                    if (rd_mem_grant) begin
                        rd_mem_req <= 1'b0;
                        to_cnt     <= '0;
                        state      <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (rd_data_valid) begin
                        state <= last_beat ? NEXT : XFR;
                    end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                        fault[1] <= 1'b1;
                        done     <= 1'b1;
                        state    <= FIN;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                XFR: begin
                    if (rd_data_valid && last_beat) begin
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    if (line_idx == lines_q - LINE_W'(1)) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        line_idx    <= line_idx + LINE_W'(1);
                        beat_idx    <= '0;
                        rd_mem_addr <= {line_idx + LINE_W'(1), {LINE_SHIFT{1'b0}}};
                        rd_mem_req  <= 1'b1;
                        state       <= REQ;
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // compare result lands one cycle after the beat was captured
            if (cmp_valid && (cmp_data != cmp_exp)) begin
                fault[0] <= 1'b1;
                if (err_cnt != '1) begin
                    err_cnt <= err_cnt + ERR_W'(1);
                end
                if (err_cnt == '0) begin
                    first_err_addr <= {cmp_line, LINE_SHIFT'(cmp_beat)};
                    first_err_data <= cmp_data;
                end
            end

            // beats outside a transfer window are flagged, never compared
            if (stray) begin
                fault[2] <= 1'b1;
            end
        end
    end

endmodule
